// File: rtl/lvds_tx_lane_framer.sv
// lvds_tx_lane_framer: 1x-clock transmit framer for one LVDS 7:1 lane.
// Sends TRAIN_PATTERN for TRAIN_WORDS cycles after reset or a training
// request, then streams words from a small FIFO, inserting IDLE_WORD on
// underrun and counting those idles once real data has been sent.
// Optional PRBS7 test-data source enabled by defining LVDS_TX_PRBS_EN.
module lvds_tx_lane_framer #(
   parameter logic [6:0] TRAIN_PATTERN = 7'b1100011,
   parameter int         TRAIN_WORDS   = 1024,
   parameter logic [6:0] IDLE_WORD     = 7'b0000000,
   parameter int         FIFO_DEPTH    = 4,
   parameter int         BIT_REVERSE   = 0
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_train_start,
   input  logic        I_din_valid,
   input  logic [6:0]  I_din,
   output logic        O_din_ready,
   input  logic        I_prbs_mode,
   output logic [6:0]  O_tx_data,
   output logic        O_train_busy,
   output logic [15:0] O_underrun_cnt
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TRAIN_WORDS - 1);
   localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic {S_TRAIN, S_DATA} state_t;

   // Output bit ordering towards the serializer.
   function automatic logic [6:0] map_word(input logic [6:0] w);
      logic [6:0] r;
      r = w;
      if (BIT_REVERSE != 0) begin
         for (int i = 0; i < 7; i++) r[i] = w[6-i];
      end
      return r;
   endfunction

   // Underrun counter saturates at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [6:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            ready_q, ready_d;
   logic [6:0]      tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            armed_q, armed_d;
   logic [15:0]     urun_q, urun_d;
   logic            wr_en, pop, flush;

`ifdef LVDS_TX_PRBS_EN
   localparam logic [6:0] PRBS_SEED = 7'h7F;
   logic [6:0] lfsr_q, lfsr_d;

   // One step of the x^7 + x^6 + 1 Fibonacci LFSR.
   function automatic logic [6:0] prbs_step(input logic [6:0] s);
      return {s[5:0], s[6] ^ s[5]};
   endfunction
`else
   logic unused_prbs_mode;
   assign unused_prbs_mode = I_prbs_mode;
`endif

   // A training request flushes the FIFO, so any write in that cycle is dropped.
   assign wr_en = I_din_valid && ready_q && !I_train_start;

   // Next-state, word selection, FIFO pointer and counter updates.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tx_d     = tx_q;
      busy_d   = busy_q;
      armed_d  = armed_q;
      urun_d   = urun_q;
      pop      = 1'b0;
      flush    = 1'b0;
`ifdef LVDS_TX_PRBS_EN
      lfsr_d   = PRBS_SEED;
`endif
      if (I_train_start) begin
         // The request cycle already carries the first pattern word, so the
         // counter starts at 1 and exactly TRAIN_WORDS pattern words go out.
         flush   = 1'b1;
         state_d = S_TRAIN;
         cnt_d   = CW'(1);
         tx_d    = map_word(TRAIN_PATTERN);
         busy_d  = 1'b1;
         armed_d = 1'b0;
      end else begin
         case (state_q)
            S_TRAIN: begin
               tx_d   = map_word(TRAIN_PATTERN);
               busy_d = 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               busy_d = 1'b0;
`ifdef LVDS_TX_PRBS_EN
               lfsr_d = lfsr_q;
               if (I_prbs_mode) begin
                  tx_d   = map_word(lfsr_q);
                  lfsr_d = prbs_step(lfsr_q);
               end else
`endif
               if (count_q != '0) begin
                  pop     = 1'b1;
                  tx_d    = map_word(mem_q[rd_ptr_q]);
                  armed_d = 1'b1;
               end else begin
                  tx_d = map_word(IDLE_WORD);
                  if (armed_q) urun_d = sat_inc(urun_q);
               end
            end
         endcase
      end

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
         case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
      // Readiness looks only at occupancy, never at a same-cycle pop.
      ready_d = (count_d != FIFO_FULL);
   end

   // Control and output registers with asynchronous reset.
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state_q  <= S_TRAIN;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
         tx_q     <= map_word(IDLE_WORD);
         busy_q   <= 1'b1;
         armed_q  <= 1'b0;
         urun_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         armed_q  <= armed_d;
         urun_q   <= urun_d;
      end
   end

`ifdef LVDS_TX_PRBS_EN
   // LFSR state; held at the seed outside DATA so every DATA entry restarts it.
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) lfsr_q <= PRBS_SEED;
      else       lfsr_q <= lfsr_d;
   end
`endif

   // FIFO storage; occupancy is tracked by the control registers.
   always_ff @(posedge I_clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= I_din;
   end

   assign O_din_ready    = ready_q;
   assign O_tx_data      = tx_q;
   assign O_train_busy   = busy_q;
   assign O_underrun_cnt = urun_q;

endmodule

// File: doc/lvds_tx_lane_framer.md
Name: lvds_tx_lane_framer

Overview:
- Transmit-side counterpart of the LVDS 7:1 receive lane. Runs in the 1x pixel-clock domain.
- Produces the 7-bit parallel word per clock that feeds the lane's 7:1 serializer.
- On reset and on request, sends a fixed training pattern long enough for the far-end receiver to finish DPA and byte alignment. It then streams user words from a small elastic FIFO, inserting idle words on underrun.

Parameters:
- TRAIN_PATTERN, 7'b1100011, word repeated during training (7:1 clock-like pattern).
- TRAIN_WORDS, 1024, number of training words sent per training run (>=2).
- IDLE_WORD, 7'b0000000, word sent in DATA when the FIFO is empty.
- FIFO_DEPTH, 4, input FIFO depth; power of two, >=2.
- BIT_REVERSE, 0, 1 = bit-reverse O_tx_data ([0] becomes [6]) to match serializer bit order.

Ports:
- I_clk, in, 1, 1x lane clock.
- I_rst, in, 1, asynchronous active-high reset.
- I_train_start, in, 1, single-cycle request to (re)start training.
- I_din_valid, in, 1, user word valid.
- I_din, in, 7, user word.
- O_din_ready, out, 1, FIFO can accept a word.
- I_prbs_mode, in, 1, PRBS7 test-data select (see Optional Feature).
- O_tx_data, out, 7, registered parallel word to the serializer.
- O_train_busy, out, 1, high while in TRAIN.
- O_underrun_cnt, out, 16, saturating count of idle words inserted due to underrun.

Behaviour:
- Reset (async, I_rst=1) values:
  - state=TRAIN, train counter=0.
  - FIFO empty, O_din_ready=0.
  - O_tx_data=IDLE_WORD (after BIT_REVERSE mapping).
  - O_train_busy=1, O_underrun_cnt=0, armed=0.
- O_din_ready is registered: it equals !full and is 0 during reset. A write occurs when I_din_valid && O_din_ready. A write is never blocked because a pop happens in the same cycle; readiness is based only on full.
- States:
  - TRAIN:
    - O_tx_data=TRAIN_PATTERN every cycle; counter increments each cycle.
    - After exactly TRAIN_WORDS pattern words go to DATA. The first DATA word appears on cycle TRAIN_WORDS after training start.
    - FIFO may fill during TRAIN but is not popped.
  - DATA:
    - FIFO not empty: pop one word per cycle into O_tx_data; set armed=1.
    - FIFO empty: O_tx_data=IDLE_WORD. If armed, O_underrun_cnt increments, saturating at 16'hFFFF.
- Latency: in DATA with an empty FIFO, a word written in cycle N appears on O_tx_data in cycle N+2. Words are sent in order, with no loss or duplication.
- I_train_start in any state, and release of reset, cause the following:
  - FIFO flushed, armed=0, counter=0, state=TRAIN.
  - A write in the same cycle as I_train_start is discarded (flush wins).
  - O_underrun_cnt is not cleared; only reset clears it.
- I_train_start during TRAIN restarts the count from 0.
- BIT_REVERSE is applied at the output register to all word sources.

Optional Feature:
- Macro: LVDS_TX_PRBS_EN.
- Defined:
  - In DATA with I_prbs_mode=1, O_tx_data carries successive 7-bit words from a PRBS7 LFSR (x^7+x^6+1, seed 7'h7F, one LFSR step per word). The seed reloads on every entry to DATA.
  - The FIFO is neither popped nor flushed; O_din_ready still follows !full.
  - Underrun counting is suspended.
  - Words are PRBS7 states 7'h7F, then successors, for the receiver error detector.
- Undefined: I_prbs_mode is ignored and there is no LFSR logic.

Test Plan:
- Reset release with TRAIN_WORDS=16 -> O_tx_data=7'b1100011 for 16 cycles with O_train_busy=1; cycle 16: O_train_busy=0, O_tx_data=7'h00.
- In DATA, write 7'h11,7'h22,7'h33 on consecutive cycles from cycle N -> O_tx_data=7'h11,7'h22,7'h33 at N+2..N+4, then 7'h00 with O_underrun_cnt=1,2,...
- Hold the FIFO stalled in TRAIN and write 4 words with FIFO_DEPTH=4 -> O_din_ready=0 after the 4th write; the 5th word is not accepted; all 4 words are sent in order after training.
- Pulse I_train_start mid-stream with 2 words queued, plus a same-cycle write of 7'h55 -> next cycle sends the training pattern; 7'h55 and the queued words are never transmitted; O_underrun_cnt is unchanged.
- Force 65540 underrun cycles -> O_underrun_cnt holds 16'hFFFF.
- With LVDS_TX_PRBS_EN defined and I_prbs_mode=1 in DATA -> first word 7'h7F followed by the PRBS7 sequence, repeating after 127 words; with the macro undefined -> IDLE_WORD/FIFO behaviour only.
